// File: rtl/grid_draw_pkg.sv
// Shared types and constants for the step-grid painter: state encoding, grid geometry,
// screen size and the square colour table.
package grid_draw_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StClear
  } state_e;

  localparam int unsigned GridX0     = 10;
  localparam int unsigned GridXStep  = 20;
  localparam int unsigned GridY0     = 20;
  localparam int unsigned GridYStep  = 20;
  localparam int unsigned GridSqSize = 4;

  localparam int unsigned ScreenW = 160;
  localparam int unsigned ScreenH = 120;

  // Colours are {R,G,B}.
  localparam logic [2:0] ColBlack  = 3'b000;
  localparam logic [2:0] ColWhite  = 3'b111;
  localparam logic [2:0] ColCyan   = 3'b011;
  localparam logic [2:0] ColRed    = 3'b100;
  localparam logic [2:0] ColGreen  = 3'b010;
  localparam logic [2:0] ColBlue   = 3'b001;
  localparam logic [2:0] ColYellow = 3'b110;

  // Instrument colour for an active step away from the cursor column.
  function automatic logic [2:0] row_colour(input logic [1:0] row);
    logic [2:0] c;
    case (row)
      2'd0:    c = ColRed;
      2'd1:    c = ColGreen;
      2'd2:    c = ColBlue;
      default: c = ColYellow;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] sq_colour(input logic on, input logic cur, input logic [1:0] row);
    logic [2:0] c;
    if (on) begin
      c = cur ? ColWhite : row_colour(row);
    end else begin
      c = cur ? ColCyan : ColBlack;
    end
    return c;
  endfunction

endpackage

// File: rtl/grid_pixel_gen.sv
// Registered pixel generator: maps the sweep counter and the frame snapshot (or a raw raster
// position while blanking) to x/y/colour with one cycle of latency.
module grid_pixel_gen
  import grid_draw_pkg::*;
#(
  parameter int unsigned X0      = GridX0,
  parameter int unsigned X_STEP  = GridXStep,
  parameter int unsigned Y0      = GridY0,
  parameter int unsigned Y_STEP  = GridYStep,
  parameter int unsigned SQ_SIZE = GridSqSize
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        raster,
  input  logic [7:0]  raster_x,
  input  logic [6:0]  raster_y,
  input  logic [8:0]  cnt,
  input  logic [31:0] draw_pat,
  input  logic [2:0]  draw_col,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour
);

  localparam int unsigned OffW = $clog2(SQ_SIZE);
  localparam logic [7:0]  X0B  = 8'(X0);
  localparam logic [6:0]  Y0B  = 7'(Y0);

  logic [4:0]      sq;
  logic [OffW-1:0] px, py;
  logic [2:0]      col;
  logic [1:0]      row;
  logic [7:0]      x_d;
  logic [6:0]      y_d;
  logic [2:0]      colour_d;

  // Square index equals the pattern bit index: {col, row}.
  assign {sq, py, px} = cnt;
  assign col = sq[4:2];
  assign row = sq[1:0];

  always_comb begin
    x_d      = X0B + 8'(32'(col) * X_STEP) + 8'(px);
    y_d      = Y0B + 7'(32'(row) * Y_STEP) + 7'(py);
    colour_d = sq_colour(draw_pat[sq], col == draw_col, row);
    if (raster) begin
      x_d      = raster_x;
      y_d      = raster_y;
      colour_d = ColBlack;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else if (en) begin
      x      <= x_d;
      y      <= y_d;
      colour <= colour_d;
    end
  end

endmodule

// File: rtl/grid_draw_ctrl.sv
// Captures the live step pattern and repaints the 8x4 grid into the vga_adapter frame buffer.
// Define GRID_CLEAR_EN to blank the whole 160x120 screen once after reset.
module grid_draw_ctrl
  import grid_draw_pkg::*;
#(
  parameter int unsigned X0      = GridX0,
  parameter int unsigned X_STEP  = GridXStep,
  parameter int unsigned Y0      = GridY0,
  parameter int unsigned Y_STEP  = GridYStep,
  parameter int unsigned SQ_SIZE = GridSqSize
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic [3:0] ins,
  input  logic [2:0] timing,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done
);

  state_e      state_q;
  logic [31:0] pattern_q, pattern_d, draw_pat_q;
  logic [2:0]  timing_q, draw_col_q;
  logic [8:0]  cnt_q;
  logic        dirty_q, last_q, cap_event;
  logic        pix_en, raster;
  logic [7:0]  raster_x;
  logic [6:0]  raster_y;

`ifdef GRID_CLEAR_EN
  localparam state_e     StReset  = StClear;
  localparam logic [7:0] ClrXLast = 8'(ScreenW - 1);
  localparam logic [6:0] ClrYLast = 7'(ScreenH - 1);

  logic [7:0] clr_x_q;
  logic [6:0] clr_y_q;

  assign raster   = (state_q == StClear);
  assign raster_x = clr_x_q;
  assign raster_y = clr_y_q;
`else
  localparam state_e StReset = StIdle;

  assign raster   = 1'b0;
  assign raster_x = '0;
  assign raster_y = '0;
`endif

  // Capture: write the current column and flag a repaint on any visible change.
  always_comb begin
    pattern_d = pattern_q;
    cap_event = 1'b0;
    if (play) begin
      pattern_d[{timing, 2'b00} +: 4] = ins;
      cap_event = (pattern_q[{timing, 2'b00} +: 4] != ins) || (timing != timing_q);
    end
  end

  assign pix_en = (state_q != StIdle);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_q  <= '0;
      timing_q   <= '0;
      dirty_q    <= 1'b1;
      state_q    <= StReset;
      cnt_q      <= '0;
      draw_pat_q <= '0;
      draw_col_q <= '0;
      last_q     <= 1'b0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef GRID_CLEAR_EN
      clr_x_q    <= '0;
      clr_y_q    <= '0;
`endif
    end else begin
      pattern_q  <= pattern_d;
      if (play) begin
        timing_q <= timing;
      end
      // Outputs track the pixel generator, which lags the sweep by one cycle.
      plot       <= (state_q != StIdle);
      busy       <= (state_q != StIdle) || last_q;
      frame_done <= last_q;
      last_q     <= 1'b0;
      dirty_q    <= dirty_q | cap_event;

      case (state_q)
        StIdle: begin
          if (dirty_q) begin
            state_q    <= StDraw;
            cnt_q      <= '0;
            draw_pat_q <= pattern_q;
            draw_col_q <= timing_q;
            // A capture in this very cycle re-arms the next frame.
            dirty_q    <= cap_event;
          end
        end
        StDraw: begin
          cnt_q <= cnt_q + 9'd1;
          if (cnt_q == 9'd511) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
          end
        end
`ifdef GRID_CLEAR_EN
        StClear: begin
          if (clr_x_q == ClrXLast) begin
            clr_x_q <= '0;
            if (clr_y_q == ClrYLast) begin
              clr_y_q <= '0;
              state_q <= StIdle;
              last_q  <= 1'b1;
              dirty_q <= 1'b1;
            end else begin
              clr_y_q <= clr_y_q + 7'd1;
            end
          end else begin
            clr_x_q <= clr_x_q + 8'd1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  grid_pixel_gen #(
    .X0      (X0),
    .X_STEP  (X_STEP),
    .Y0      (Y0),
    .Y_STEP  (Y_STEP),
    .SQ_SIZE (SQ_SIZE)
  ) u_pixel_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (pix_en),
    .raster   (raster),
    .raster_x (raster_x),
    .raster_y (raster_y),
    .cnt      (cnt_q),
    .draw_pat (draw_pat_q),
    .draw_col (draw_col_q),
    .x        (x),
    .y        (y),
    .colour   (colour)
  );

endmodule

// File: tb/tb_grid_draw_ctrl.sv
// Directed bench for grid_draw_ctrl: frames are captured pixel by pixel and compared with
// hand-derived geometry, colours and control timing.
module tb_grid_draw_ctrl;

  logic       clk;
  logic       reset;
  logic       play;
  logic [3:0] ins;
  logic [2:0] timing;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] fx [512];
  logic [6:0] fy [512];
  logic [2:0] fc [512];

  grid_draw_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .ins        (ins),
    .timing     (timing),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_colour(input logic [31:0] pat, input int cur, input int col,
                                    input int row);
    if (pat[col*4+row]) begin
      if (col == cur) return 7;
      case (row)
        0:       return 4;
        1:       return 2;
        2:       return 1;
        default: return 6;
      endcase
    end
    return (col == cur) ? 3 : 0;
  endfunction

  // Waits for the first plot, records 512 pixels, optionally pokes a capture at cycle inj_at.
  task automatic grab_frame(input string tag, input logic [31:0] pat, input int cur,
                            input int inj_at, input logic [3:0] inj_ins);
    bit seen = 0;
    int nplot = 0;
    int nctl = 0;
    int npix = 0;
    int sq, col, row, px, py;
    for (int i = 0; i < 25000 && !seen; i++) begin
      @(negedge clk);
      seen = plot;
    end
    chk({tag, " plot start"}, 32'(seen), 1);
    if (!seen) return;
    for (int i = 0; i < 512; i++) begin
      if (i > 0) @(negedge clk);
      fx[i] = x;
      fy[i] = y;
      fc[i] = colour;
      nplot += int'(plot);
      if (busy !== 1'b1 || frame_done !== 1'b0) nctl++;
      sq  = i / 16;
      col = sq / 4;
      row = sq % 4;
      px  = i % 4;
      py  = (i / 4) % 4;
      if (32'(x) !== 32'(10 + 20*col + px) || 32'(y) !== 32'(20 + 20*row + py) ||
          32'(colour) !== 32'(exp_colour(pat, cur, col, row))) npix++;
      if (i == inj_at) begin
        play = 1'b1;
        ins  = inj_ins;
      end else if (i == inj_at + 1) begin
        play = 1'b0;
      end
    end
    chk({tag, " plots"}, 32'(nplot), 512);
    chk({tag, " busy/done during"}, 32'(nctl), 0);
    chk({tag, " pixels"}, 32'(npix), 0);
    @(negedge clk);
    chk({tag, " done fd/busy/plot"}, 32'({frame_done, busy, plot}), 6);
  endtask

  task automatic expect_idle(input string tag, input int n);
    int nact = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (plot !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) nact++;
    end
    chk(tag, 32'(nact), 0);
  endtask

`ifdef GRID_CLEAR_EN
  task automatic grab_clear(input string tag);
    bit seen = 0;
    int nplot = 0;
    int nbad = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = plot;
    end
    chk({tag, " plot start"}, 32'(seen), 1);
    if (!seen) return;
    for (int i = 0; i < 19200; i++) begin
      if (i > 0) @(negedge clk);
      nplot += int'(plot);
      if (32'(x) !== 32'(i % 160) || 32'(y) !== 32'(i / 160) || colour !== 3'b000 ||
          busy !== 1'b1) nbad++;
    end
    chk({tag, " plots"}, 32'(nplot), 19200);
    chk({tag, " raster"}, 32'(nbad), 0);
    @(negedge clk);
    chk({tag, " done fd/busy/plot"}, 32'({frame_done, busy, plot}), 6);
  endtask
`endif

  initial begin
    bit seen;
    reset  = 1'b1;
    play   = 1'b0;
    ins    = 4'b0000;
    timing = 3'd0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset x/y/colour", 32'({x, y, colour}), 0);
    chk("reset plot/busy/done", 32'({plot, busy, frame_done}), 0);
    reset = 1'b1;

    // Frame after reset: empty pattern, cursor on column 0.
`ifdef GRID_CLEAR_EN
    grab_clear("clear0");
`endif
    grab_frame("f1", 32'h0, 0, -1, 4'b0000);
    chk("f1 first x", 32'(fx[0]), 10);
    chk("f1 first y", 32'(fy[0]), 20);
    chk("f1 first colour", 32'(fc[0]), 3);
    chk("f1 last x", 32'(fx[511]), 153);
    chk("f1 last y", 32'(fy[511]), 83);
    chk("f1 last colour", 32'(fc[511]), 0);
    expect_idle("f1 idle after", 20);

    // Column 2 gets rows 0 and 2.
    play   = 1'b1;
    timing = 3'd2;
    ins    = 4'b0101;
    @(negedge clk);
    play = 1'b0;
    grab_frame("f2", 32'h0000_0500, 2, -1, 4'b0000);
    chk("f2 col2 row0", 32'(fc[128]), 7);
    chk("f2 col2 row1", 32'(fc[144]), 3);
    chk("f2 col2 row2", 32'(fc[160]), 7);
    chk("f2 col0 row0", 32'(fc[0]), 0);
    expect_idle("f2 idle after", 20);

    // Step timing 2 -> 3 with ins=0001: the second capture lands during the first frame start.
    play   = 1'b1;
    timing = 3'd2;
    ins    = 4'b0001;
    @(negedge clk);
    timing = 3'd3;
    @(negedge clk);
    play = 1'b0;
    grab_frame("f3a", 32'h0000_0100, 2, -1, 4'b0000);
    chk("f3a col2 row0", 32'(fc[128]), 7);
    grab_frame("f3b", 32'h0000_1100, 3, -1, 4'b0000);
    chk("f3b col2 row0", 32'(fc[128]), 4);
    chk("f3b col3 row0", 32'(fc[192]), 7);
    expect_idle("f3 idle after", 20);

    // Pattern change at plot cycle 100: current frame keeps its snapshot, one more follows.
    play = 1'b1;
    ins  = 4'b0011;
    @(negedge clk);
    play = 1'b0;
    grab_frame("f4a", 32'h0000_3100, 3, 100, 4'b1011);
    chk("f4a col3 row3", 32'(fc[240]), 3);
    grab_frame("f4b", 32'h0000_B100, 3, -1, 4'b0000);
    chk("f4b col3 row3", 32'(fc[240]), 7);
    chk("f4b col3 row2", 32'(fc[224]), 3);
    expect_idle("f4 no third frame", 40);

    // Reset in the middle of a frame.
    play = 1'b1;
    ins  = 4'b0111;
    @(negedge clk);
    play = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = plot;
    end
    chk("f5 plot start", 32'(seen), 1);
    repeat (300) @(negedge clk);
    chk("f5 plot at cycle 300", 32'(plot), 1);
    reset = 1'b0;
    #1;
    chk("mid reset x/y/colour", 32'({x, y, colour}), 0);
    chk("mid reset plot/busy/done", 32'({plot, busy, frame_done}), 0);
    @(negedge clk);
    reset = 1'b1;
`ifdef GRID_CLEAR_EN
    grab_clear("clear1");
`endif
    grab_frame("f6", 32'h0, 0, -1, 4'b0000);
    expect_idle("f6 idle after", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
